// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_cmd_pkg : shared types and constants for the UART command framer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GET_HI = 2'd1,
    GET_LO = 2'd2
  } frm_state_t;

  localparam int SHORT_CMD_BIT = 7;
  localparam int TMO_W         = 16;

endpackage
`default_nettype wire

// File: rtl/uart_tmo_cntr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tmo_cntr : inter-byte timeout counter, flags count = TMO-1       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_tmo_cntr
  import uart_cmd_pkg::*;
#(
  parameter int TMO_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  logic [TMO_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == TMO_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_cmd_framer : drains UART bytes into 1- or 3-byte commands        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_cmd_framer
  import uart_cmd_pkg::*;
#(
  parameter int TMO_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [7:0]  cmd_op,
  output logic [15:0] cmd_data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  frm_state_t  state_q;
  logic [7:0]  op_hold_q;
  logic [7:0]  hi_hold_q;
  logic        clr_rx_rdy_q;
  logic [7:0]  cmd_op_q;
  logic [15:0] cmd_data_q;
  logic        cmd_rdy_q;
  logic        frame_err_q;
  logic        overrun_q;
  logic        busy_q;

  logic        w_accept;
  logic        w_expired;
  logic        w_done;
  logic [7:0]  w_op_d;
  logic [15:0] w_data_d;

  // The registered clear blocks the cycle in which the receiver drops rx_rdy
  assign w_accept = rx_rdy & ~clr_rx_rdy_q;

  uart_tmo_cntr #(
    .TMO_CYCLES(TMO_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_accept | (state_q == IDLE)),
    .en     (state_q != IDLE),
    .expired(w_expired)
  );

  always_comb begin
    w_done   = 1'b0;
    w_op_d   = rx_data;
    w_data_d = 16'h0000;
    if (w_accept) begin
      if (state_q == GET_LO) begin
        w_done   = 1'b1;
        w_op_d   = op_hold_q;
        w_data_d = {hi_hold_q, rx_data};
      end else if (state_q == IDLE && rx_data[SHORT_CMD_BIT]) begin
        w_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_hold_q    <= 8'h00;
      hi_hold_q    <= 8'h00;
      clr_rx_rdy_q <= 1'b0;
      cmd_op_q     <= 8'h00;
      cmd_data_q   <= 16'h0000;
      cmd_rdy_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      clr_rx_rdy_q <= w_accept;
      frame_err_q  <= 1'b0;
      overrun_q    <= w_done & cmd_rdy_q & ~clr_cmd_rdy;

      // Completion takes priority over a simultaneous consumer clear
      if (w_done) begin
        cmd_op_q   <= w_op_d;
        cmd_data_q <= w_data_d;
        cmd_rdy_q  <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (w_accept && !rx_data[SHORT_CMD_BIT]) begin
            op_hold_q <= rx_data;
            state_q   <= GET_HI;
            busy_q    <= 1'b1;
          end
        end
        GET_HI: begin
          if (w_accept) begin
            hi_hold_q <= rx_data;
            state_q   <= GET_LO;
          end else if (w_expired) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
          end
        end
        GET_LO: begin
          if (w_accept) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (w_expired) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_rx_rdy = clr_rx_rdy_q;
  assign cmd_op     = cmd_op_q;
  assign cmd_data   = cmd_data_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_framer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_cmd_framer : randomized bench with a frame-level model       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_cmd_framer;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  uart_cmd_framer #(.TMO_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int ferr_cnt = 0;
  int ferr_cyc = -1;
  int ovr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err === 1'b1) begin
      ferr_cnt <= ferr_cnt + 1;
      ferr_cyc <= cyc;
    end
    if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
  end

  // Frame-level reference: bytes collected in a queue, timeouts judged from accept cycles
  logic [7:0]  m_frame[$];
  logic [7:0]  m_op = 8'h00;
  logic [15:0] m_data = 16'h0000;
  bit          m_rdy = 1'b0;
  bit          m_ovr = 1'b0;
  int          m_ferr = 0;
  int          m_ferr_cyc = -1;
  int          m_ovr_cnt = 0;
  int          m_last_acc = 0;

  int nvec = 0;
  int nerr = 0;

  task automatic model_settle(input int now);
    if (m_frame.size() > 0 && now > m_last_acc + TMO) begin
      m_frame.delete();
      m_ferr++;
      m_ferr_cyc = m_last_acc + TMO + 1;
    end
  endtask

  task automatic model_step(input logic [7:0] b, input bit clr, input int acc);
    bit done;
    model_settle(acc);
    m_frame.push_back(b);
    m_last_acc = acc;
    done = (m_frame.size() == 1 && b[7]) || (m_frame.size() == 3);
    m_ovr = 1'b0;
    if (done) begin
      m_ovr  = m_rdy && !clr;
      m_op   = m_frame[0];
      m_data = (m_frame.size() == 3) ? {m_frame[1], m_frame[2]} : 16'h0000;
      m_rdy  = 1'b1;
      m_frame.delete();
      if (m_ovr) m_ovr_cnt++;
    end else if (clr) begin
      m_rdy = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_op = 8'h00;
    m_data = 16'h0000;
    m_rdy = 1'b0;
  endtask

  task automatic idle_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Entered in the cycle where rx_rdy is already high and the byte is accepted
  task automatic finish_byte(input logic [7:0] b, input bit clr);
    bit exp_busy;
    model_step(b, clr, cyc);
    exp_busy = (m_frame.size() > 0);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    nvec++; if (clr_rx_rdy !== 1'b1) begin nerr++; $display("FAIL clr_pulse byte %h: got %b want 1", b, clr_rx_rdy); end
    nvec++; if (cmd_op !== m_op) begin nerr++; $display("FAIL cmd_op byte %h: got %h want %h", b, cmd_op, m_op); end
    nvec++; if (cmd_data !== m_data) begin nerr++; $display("FAIL cmd_data byte %h: got %h want %h", b, cmd_data, m_data); end
    nvec++; if (cmd_rdy !== m_rdy) begin nerr++; $display("FAIL cmd_rdy byte %h: got %b want %b", b, cmd_rdy, m_rdy); end
    nvec++; if (overrun !== m_ovr) begin nerr++; $display("FAIL overrun byte %h: got %b want %b", b, overrun, m_ovr); end
    nvec++; if (busy !== exp_busy) begin nerr++; $display("FAIL busy byte %h: got %b want %b", b, busy, exp_busy); end
    @(negedge clk);
    rx_rdy = 1'b0;
    nvec++; if (clr_rx_rdy !== 1'b0) begin nerr++; $display("FAIL clr_once byte %h: got %b want 0", b, clr_rx_rdy); end
    nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL ovr_once byte %h: got %b want 0", b, overrun); end
    nvec++; if (cmd_op !== m_op || cmd_rdy !== m_rdy || busy !== exp_busy) begin
      nerr++; $display("FAIL no_reaccept byte %h: got op %h rdy %b busy %b want op %h rdy %b busy %b",
                       b, cmd_op, cmd_rdy, busy, m_op, m_rdy, exp_busy);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit clr);
    rx_rdy = 1'b1;
    rx_data = b;
    clr_cmd_rdy = clr;
    finish_byte(b, clr);
  endtask

  task automatic clr_pulse();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    nvec++; if (cmd_rdy !== 1'b0) begin nerr++; $display("FAIL clr_cmd_rdy: got %b want 0", cmd_rdy); end
  endtask

  task automatic check_counts(input string tag);
    model_settle(cyc);
    nvec++; if (ferr_cnt !== m_ferr) begin nerr++; $display("FAIL %s frame_err count: got %0d want %0d", tag, ferr_cnt, m_ferr); end
    nvec++; if (ovr_cnt !== m_ovr_cnt) begin nerr++; $display("FAIL %s overrun count: got %0d want %0d", tag, ovr_cnt, m_ovr_cnt); end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    nvec++; if ({clr_rx_rdy, cmd_rdy, frame_err, overrun, busy} !== 5'b0) begin
      nerr++; $display("FAIL reset flags: got %b want 00000", {clr_rx_rdy, cmd_rdy, frame_err, overrun, busy});
    end
    nvec++; if (cmd_op !== 8'h00 || cmd_data !== 16'h0000) begin
      nerr++; $display("FAIL reset cmd: got %h/%h want 00/0000", cmd_op, cmd_data);
    end
    @(negedge clk);
  endtask

  task automatic test_long();
    send_byte(8'h12, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    nvec++; if (cmd_op !== 8'h12 || cmd_data !== 16'hABCD) begin
      nerr++; $display("FAIL long cmd: got %h/%h want 12/abcd", cmd_op, cmd_data);
    end
    clr_pulse();
  endtask

  task automatic test_short();
    send_byte(8'h85, 1'b0);
    nvec++; if (cmd_op !== 8'h85 || cmd_data !== 16'h0000 || cmd_rdy !== 1'b1) begin
      nerr++; $display("FAIL short cmd: got %h/%h/%b want 85/0000/1", cmd_op, cmd_data, cmd_rdy);
    end
    clr_pulse();
  endtask

  task automatic test_timeout();
    int n0;
    send_byte(8'h12, 1'b0);
    n0 = m_last_acc;
    idle_until(n0 + TMO + 4);
    check_counts("timeout");
    nvec++; if (ferr_cyc !== n0 + TMO + 1) begin nerr++; $display("FAIL frame_err cycle: got %0d want %0d", ferr_cyc, n0 + TMO + 1); end
    nvec++; if (busy !== 1'b0 || cmd_rdy !== 1'b0) begin nerr++; $display("FAIL after timeout busy/rdy: got %b%b want 00", busy, cmd_rdy); end
    send_byte(8'h90, 1'b0);
    clr_pulse();
    // Accepts at 99 cycles and exactly at the expiry cycle both beat the timeout
    send_byte(8'h12, 1'b0);
    n0 = m_last_acc;
    idle_until(n0 + TMO - 1);
    send_byte(8'h34, 1'b0);
    n0 = m_last_acc;
    idle_until(n0 + TMO);
    send_byte(8'h56, 1'b0);
    nvec++; if (cmd_op !== 8'h12 || cmd_data !== 16'h3456) begin
      nerr++; $display("FAIL boundary cmd: got %h/%h want 12/3456", cmd_op, cmd_data);
    end
    check_counts("boundary");
    clr_pulse();
  endtask

  task automatic test_overrun();
    send_byte(8'h81, 1'b0);
    send_byte(8'h82, 1'b0);
    send_byte(8'h83, 1'b1);
    nvec++; if (cmd_op !== 8'h83 || cmd_rdy !== 1'b1) begin
      nerr++; $display("FAIL clr_vs_set: got %h/%b want 83/1", cmd_op, cmd_rdy);
    end
    check_counts("overrun");
    clr_pulse();
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    rst = 1'b1; rx_rdy = 1'b1; rx_data = 8'h88;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    nvec++; if (busy !== 1'b0 || clr_rx_rdy !== 1'b0 || cmd_rdy !== 1'b0 || cmd_op !== 8'h00) begin
      nerr++; $display("FAIL midframe reset: got busy %b clr %b rdy %b op %h want 0 0 0 00", busy, clr_rx_rdy, cmd_rdy, cmd_op);
    end
    finish_byte(8'h88, 1'b0);
    idle_until(cyc + TMO + 5);
    check_counts("midframe");
    clr_pulse();
  endtask

  task automatic test_random();
    logic [7:0] b;
    int d;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) clr_pulse();
      d = ($urandom_range(0, 6) == 0) ? int'($urandom_range(TMO - 1, TMO + 2)) : int'($urandom_range(2, 6));
      idle_until(m_last_acc + d);
      b = 8'($urandom);
      send_byte(b, $urandom_range(0, 3) == 0);
    end
    idle_until(cyc + TMO + 5);
    check_counts("random");
  endtask

  initial begin
    test_reset();
    test_long();
    test_short();
    test_timeout();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_framer.md
# uart_cmd_framer

Command-framing controller sitting directly behind the UART receiver. It drains received bytes using the receiver's `rx_rdy`/`clr_rx_rdy` handshake and assembles them into 1-byte or 3-byte commands. It enforces an inter-byte timeout and presents each completed command to the downstream command processor with a ready/clear handshake.

## Interface
Parameters:
- `TMO_CYCLES`, default 65535: inter-byte timeout in clk cycles, measured from the last accepted byte of an incomplete frame. Legal range 2..65535.

Ports:
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset. Single clock domain; reset is sampled on the `clk` rising edge only.
- `rx_rdy`, input, 1: byte-available flag from the UART receiver; stays high until cleared.
- `rx_data`, input, 8: received byte; valid while `rx_rdy`=1.
- `clr_rx_rdy`, output, 1: one-cycle pulse that consumes the current byte.
- `cmd_op`, output, 8: opcode of the last completed command.
- `cmd_data`, output, 16: payload of the last completed command, {byte2, byte3}.
- `cmd_rdy`, output, 1: completed command available; sticky until cleared.
- `clr_cmd_rdy`, input, 1: downstream consumer clears `cmd_rdy`.
- `frame_err`, output, 1: one-cycle pulse on inter-byte timeout.
- `overrun`, output, 1: one-cycle pulse when a command completes while `cmd_rdy` is already 1.
- `busy`, output, 1: high while a frame is partially received (state is not IDLE).

## Operation
- Byte accept condition: `rx_rdy`=1 and `clr_rx_rdy`=0. `clr_rx_rdy` is registered, so the cycle after an accept is blocked while the receiver drops `rx_rdy`.
- On accept: latch `rx_data` and drive `clr_rx_rdy`=1 on the next cycle, for exactly one cycle.
- FSM states: IDLE, GET_HI, GET_LO.
  - IDLE, accept with `rx_data[7]`=1 (short command): `cmd_op`<=byte, `cmd_data`<=0x0000, set `cmd_rdy`, stay in IDLE.
  - IDLE, accept with `rx_data[7]`=0 (long command): hold the opcode internally, go to GET_HI.
  - GET_HI, accept: hold `cmd_data[15:8]`, go to GET_LO.
  - GET_LO, accept: `cmd_op`/`cmd_data` <= the assembled frame, set `cmd_rdy`, go to IDLE.
  - GET_HI or GET_LO, timeout: go to IDLE, pulse `frame_err`, discard the partial frame. `cmd_op`, `cmd_data` and `cmd_rdy` are untouched.
- Timeout counter, 16 bits:
  - Cleared in IDLE and on every accept.
  - Increments each cycle in GET_HI or GET_LO.
  - Timeout fires when the counter = `TMO_CYCLES`-1 and no accept occurs that cycle. An accept in the same cycle wins and the timeout does not fire.
- `cmd_rdy`:
  - Set on frame completion; cleared by `clr_cmd_rdy`.
  - Completion and `clr_cmd_rdy` in the same cycle: set wins, and `cmd_rdy` stays 1.
- Overrun: completion while `cmd_rdy`=1 and `clr_cmd_rdy`=0 overwrites `cmd_op`/`cmd_data`, keeps `cmd_rdy`=1, and pulses `overrun`.
- `cmd_op`/`cmd_data` change only on completion. Downstream logic may sample them any time `cmd_rdy`=1.

## Timing
- Reset values: state IDLE; `clr_rx_rdy`=0, `cmd_op`=0x00, `cmd_data`=0x0000, `cmd_rdy`=0, `frame_err`=0, `overrun`=0, `busy`=0; timeout counter 0.
- Reset mid-frame: the partial frame is lost. A byte pending on `rx_rdy` during reset is not cleared; it is accepted as a new first byte on the first cycle after `rst` deasserts.
- Accept in cycle N:
  - `clr_rx_rdy`=1 in cycle N+1.
  - `cmd_rdy`, `cmd_op`, `cmd_data`, `overrun` and state update are visible in cycle N+1.
- Maximum throughput: one byte accepted every 2 cycles. The UART byte period is far longer, so the framer never stalls the receiver.
- Timeout: with the last accept in cycle N, `frame_err` pulses in cycle N+`TMO_CYCLES`+1 and `busy` is 0 from that same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `uart_cmd_pkg`:
  - `typedef enum logic [1:0] {IDLE, GET_HI, GET_LO} frm_state_t`
  - `localparam SHORT_CMD_BIT = 7`
  - `localparam TMO_W = 16`
- One sub-module, `uart_tmo_cntr`:
  - Inputs: `clk`, `rst`, `clr`, `en`.
  - Output: `expired`, combinational on count = `TMO_CYCLES`-1.
  - The FSM combines `expired` with the accept condition.
- The FSM and output registers live in `uart_cmd_framer`. Expected size: roughly 150–200 lines of RTL.

## Test plan
- Long command: bytes 0x12, 0xAB, 0xCD, each presented via `rx_rdy` -> `clr_rx_rdy` pulses once per byte; `cmd_op`=0x12, `cmd_data`=0xABCD, and `cmd_rdy`=1 one cycle after the third accept; `busy`=0.
- Short command: byte 0x85 -> `cmd_op`=0x85, `cmd_data`=0x0000, `cmd_rdy`=1; `busy` never asserts.
- Timeout with `TMO_CYCLES`=100: byte 0x12, then silence -> `frame_err` pulses exactly 101 cycles after the accept; `cmd_rdy` stays 0; a following 0x90 completes as a short command. A second byte arriving at 99 cycles must not time out.
- Overrun and clear: complete 0x81, leave it uncleared, complete 0x82 -> `overrun` pulses once, `cmd_op`=0x82, `cmd_rdy`=1. Then `clr_cmd_rdy` coinciding with completion of 0x83 -> `cmd_rdy` remains 1 and `cmd_op`=0x83.
- Reset mid-frame: 0x12, 0x34, assert `rst` for 1 cycle, then 0x88 -> `busy`=0 after reset; `cmd_op`=0x88, `cmd_data`=0x0000; no `frame_err` pulse.
